sys_array_lock_arbiter: RTL and testbench

Shares the systolic-array controller's two resources, the load path (B) and the compute path (A/D/C), between thread 0 and thread 1. Each resource has an independent round-robin lock. The block latches the winning thread's addresses, issues a one-cycle start to the array controller, and holds the grant until the controller pulses finished. It sits between the two `thread` instances and `sys_array_controller` inside `core`.

---
 rtl/sys_array_lock_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_sys_array_lock_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_lock_arbiter.sv
// sys_array_lock_arbiter
// ----------------------------------------------------------------------------
// Shares the systolic-array controller's load path (B) and compute path
// (A/D/C) between thread 0 and thread 1. Each path has its own round-robin
// lock built from one sys_array_lock_arb instance. The winning thread's
// addresses are latched, a one-cycle start pulse goes to the controller and
// the grant is held until the controller pulses finished.
//
// Optional feature macro: LOCK_TIMEOUT_EN
//   defined   : a grant held for TIMEOUT_CYCLES busy cycles without finished
//               is force-released and the sticky timeout_err bit is set.
//   undefined : no counter, timeout_err tied to 00, grants held until finished.
//
// Ports
//   clock, reset              clock, synchronous active-high reset
//   load_lock_req[1:0]        per-thread load lock request (level)
//   B_addr0/1                 per-thread B tile address
//   load_lock_res[1:0]        one-hot load grant (level)
//   load_finished             controller pulse: load done
//   ctl_load_start            one-cycle start pulse to controller
//   ctl_B_addr                latched B address of the load owner
//   comp_lock_req[1:0]        per-thread compute lock request (level)
//   A/D/C_addr0/1             per-thread compute addresses
//   comp_lock_res[1:0]        one-hot compute grant (level)
//   comp_finished             controller pulse: compute done
//   ctl_comp_start            one-cycle start pulse
//   ctl_A/D/C_addr            latched compute owner addresses
//   timeout_err[1:0]          sticky timeout flags (bit0 load, bit1 compute)
//   load_state, comp_state    debug view of each arbiter FSM
//                             (0 = IDLE, 1 = BUSY, 2 = HOLDOFF)
//
// Handshake: req is a level; a grant is issued from IDLE on the edge that
// samples req, res then stays high through the whole operation regardless of
// req, and drops on the edge that samples finished. One HOLDOFF cycle follows
// so the old owner can drop req before the next arbitration.
// ----------------------------------------------------------------------------

// One round-robin lock with NUM_ADDR latched address fields per thread.
module sys_array_lock_arb #(
  parameter int BITWIDTH       = 32,
  parameter int NUM_ADDR       = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   req,
  input  logic [NUM_ADDR*BITWIDTH-1:0] addr0,
  input  logic [NUM_ADDR*BITWIDTH-1:0] addr1,
  input  logic                         finished,
  output logic [1:0]                   res,
  output logic                         start,
  output logic [NUM_ADDR*BITWIDTH-1:0] ctl_addr,
  output logic                         timeout_err,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_HOLDOFF = 2'd2
  } arb_state_t;

  arb_state_t state, state_nxt;
  logic       last_owner;
  logic       owner;
  logic       grant;
  logic       grant_id;
  logic       release_op;
  logic       timeout_hit;

  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_id   = 1'b0;
    release_op = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          grant     = 1'b1;
          // On a tie the thread that did not own the lock last time wins.
          grant_id  = (req == 2'b11) ? ~last_owner : req[1];
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (finished || timeout_hit) begin
          release_op = 1'b1;
          state_nxt  = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      res        <= 2'b00;
      start      <= 1'b0;
      ctl_addr   <= '0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
    end else begin
      state <= state_nxt;
      start <= grant;
      if (grant) begin
        res      <= grant_id ? 2'b10 : 2'b01;
        owner    <= grant_id;
        ctl_addr <= grant_id ? addr1 : addr0;
      end
      if (release_op) begin
        res        <= 2'b00;
        last_owner <= owner;
      end
    end
  end

`ifdef LOCK_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] busy_cnt;

  // Counter holds the number of busy edges already seen, so hitting
  // TIMEOUT_CYCLES-1 means this edge is the TIMEOUT_CYCLES-th busy edge.
  assign timeout_hit = (state == ST_BUSY) && (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant) begin
        busy_cnt <= '0;
      end else if (state == ST_BUSY) begin
        busy_cnt <= busy_cnt + 1'b1;
      end
      // A real finished on the same edge counts as a normal completion.
      if (timeout_hit && !finished) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

module sys_array_lock_arbiter #(
  parameter int BITWIDTH       = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          load_lock_req,
  input  logic [BITWIDTH-1:0] B_addr0,
  input  logic [BITWIDTH-1:0] B_addr1,
  output logic [1:0]          load_lock_res,
  input  logic                load_finished,
  output logic                ctl_load_start,
  output logic [BITWIDTH-1:0] ctl_B_addr,
  input  logic [1:0]          comp_lock_req,
  input  logic [BITWIDTH-1:0] A_addr0,
  input  logic [BITWIDTH-1:0] A_addr1,
  input  logic [BITWIDTH-1:0] D_addr0,
  input  logic [BITWIDTH-1:0] D_addr1,
  input  logic [BITWIDTH-1:0] C_addr0,
  input  logic [BITWIDTH-1:0] C_addr1,
  output logic [1:0]          comp_lock_res,
  input  logic                comp_finished,
  output logic                ctl_comp_start,
  output logic [BITWIDTH-1:0] ctl_A_addr,
  output logic [BITWIDTH-1:0] ctl_D_addr,
  output logic [BITWIDTH-1:0] ctl_C_addr,
  output logic [1:0]          timeout_err,
  output logic [1:0]          load_state,
  output logic [1:0]          comp_state
);

  logic [3*BITWIDTH-1:0] comp_ctl_addr;

  sys_array_lock_arb #(
    .BITWIDTH      (BITWIDTH),
    .NUM_ADDR      (1),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_load_arb (
    .clock      (clock),
    .reset      (reset),
    .req        (load_lock_req),
    .addr0      (B_addr0),
    .addr1      (B_addr1),
    .finished   (load_finished),
    .res        (load_lock_res),
    .start      (ctl_load_start),
    .ctl_addr   (ctl_B_addr),
    .timeout_err(timeout_err[0]),
    .state_dbg  (load_state)
  );

  // Compute addresses are packed as {C, D, A}.
  sys_array_lock_arb #(
    .BITWIDTH      (BITWIDTH),
    .NUM_ADDR      (3),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_comp_arb (
    .clock      (clock),
    .reset      (reset),
    .req        (comp_lock_req),
    .addr0      ({C_addr0, D_addr0, A_addr0}),
    .addr1      ({C_addr1, D_addr1, A_addr1}),
    .finished   (comp_finished),
    .res        (comp_lock_res),
    .start      (ctl_comp_start),
    .ctl_addr   (comp_ctl_addr),
    .timeout_err(timeout_err[1]),
    .state_dbg  (comp_state)
  );

  assign ctl_A_addr = comp_ctl_addr[BITWIDTH-1:0];
  assign ctl_D_addr = comp_ctl_addr[2*BITWIDTH-1:BITWIDTH];
  assign ctl_C_addr = comp_ctl_addr[3*BITWIDTH-1:2*BITWIDTH];

endmodule

// File: tb/tb_sys_array_lock_arbiter.sv
// Testbench for sys_array_lock_arbiter: directed scenarios followed by random
// traffic, every cycle checked against a transaction-level lock model.
module tb_sys_array_lock_arbiter;

  localparam int BW  = 32;
  localparam int TMO = 8;
`ifdef LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [1:0]    load_lock_req, comp_lock_req;
  logic [BW-1:0] B_addr0, B_addr1, A_addr0, A_addr1, D_addr0, D_addr1, C_addr0, C_addr1;
  logic          load_finished, comp_finished;
  logic [1:0]    load_lock_res, comp_lock_res, timeout_err, load_state, comp_state;
  logic          ctl_load_start, ctl_comp_start;
  logic [BW-1:0] ctl_B_addr, ctl_A_addr, ctl_D_addr, ctl_C_addr;

  sys_array_lock_arbiter #(.BITWIDTH(BW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .load_lock_req(load_lock_req), .B_addr0(B_addr0), .B_addr1(B_addr1),
    .load_lock_res(load_lock_res), .load_finished(load_finished),
    .ctl_load_start(ctl_load_start), .ctl_B_addr(ctl_B_addr),
    .comp_lock_req(comp_lock_req),
    .A_addr0(A_addr0), .A_addr1(A_addr1), .D_addr0(D_addr0), .D_addr1(D_addr1),
    .C_addr0(C_addr0), .C_addr1(C_addr1),
    .comp_lock_res(comp_lock_res), .comp_finished(comp_finished),
    .ctl_comp_start(ctl_comp_start),
    .ctl_A_addr(ctl_A_addr), .ctl_D_addr(ctl_D_addr), .ctl_C_addr(ctl_C_addr),
    .timeout_err(timeout_err), .load_state(load_state), .comp_state(comp_state)
  );

  // ---------------- scoreboard counters / check task ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index k: 0 = load lock, 1 = compute lock. A lock is either owned
  // (owner >= 0) or free; after a release it refuses new grants for
  // one edge (gap). busy counts edges spent owned.
  int            m_owner[2];
  int            m_gap[2];
  int            m_last[2];
  int            m_busy[2];
  logic          m_start[2];
  logic [1:0]    m_err;
  logic [BW-1:0] m_addr[2][3];

  function automatic logic [BW-1:0] addr_of(input int thr, input int k, input int j);
    if (k == 0) return (thr == 0) ? B_addr0 : B_addr1;
    case (j)
      0:       return (thr == 0) ? A_addr0 : A_addr1;
      1:       return (thr == 0) ? D_addr0 : D_addr1;
      default: return (thr == 0) ? C_addr0 : C_addr1;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_gap[k] = 0; m_last[k] = 1; m_busy[k] = 0; m_start[k] = 1'b0;
      for (int j = 0; j < 3; j++) m_addr[k][j] = '0;
    end
    m_err = 2'b00;
  endtask

  task automatic model_step(input int k, input logic [1:0] r, input logic f);
    int pick;
    m_start[k] = 1'b0;
    if (m_owner[k] >= 0) begin
      m_busy[k] = m_busy[k] + 1;
      if (f || (TO_EN && m_busy[k] == TMO)) begin
        if (!f) m_err[k] = 1'b1;
        m_last[k]  = m_owner[k];
        m_owner[k] = -1;
        m_gap[k]   = 1;
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k] = m_gap[k] - 1;
    end else if (r != 2'b00) begin
      if (r == 2'b11) pick = 1 - m_last[k];
      else            pick = r[0] ? 0 : 1;
      m_owner[k] = pick;
      m_busy[k]  = 0;
      m_start[k] = 1'b1;
      for (int j = 0; j < 3; j++) m_addr[k][j] = addr_of(pick, k, j);
    end
  endtask

  function automatic logic [1:0] exp_res(input int k);
    if (m_owner[k] < 0) return 2'b00;
    return (m_owner[k] == 0) ? 2'b01 : 2'b10;
  endfunction

  // One clock: model consumes the inputs sampled at this edge, then all
  // outputs are compared 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else begin
      model_step(0, load_lock_req, load_finished);
      model_step(1, comp_lock_req, comp_finished);
    end
    #1;
    check("load_res",   {30'd0, load_lock_res},  {30'd0, exp_res(0)});
    check("load_start", {31'd0, ctl_load_start}, {31'd0, m_start[0]});
    check("ctl_B",      ctl_B_addr,              m_addr[0][0]);
    check("comp_res",   {30'd0, comp_lock_res},  {30'd0, exp_res(1)});
    check("comp_start", {31'd0, ctl_comp_start}, {31'd0, m_start[1]});
    check("ctl_A",      ctl_A_addr,              m_addr[1][0]);
    check("ctl_D",      ctl_D_addr,              m_addr[1][1]);
    check("ctl_C",      ctl_C_addr,              m_addr[1][2]);
    check("tmo_err",    {30'd0, timeout_err},    {30'd0, m_err});
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_addrs();
    B_addr0 = $urandom; B_addr1 = $urandom;
    A_addr0 = $urandom; A_addr1 = $urandom;
    D_addr0 = $urandom; D_addr1 = $urandom;
    C_addr0 = $urandom; C_addr1 = $urandom;
  endtask

  task automatic idle_inputs();
    load_lock_req = 2'b00; comp_lock_req = 2'b00;
    load_finished = 1'b0;  comp_finished = 1'b0;
  endtask

  task automatic pulse_load_fin();
    load_finished = 1'b1; tick(); load_finished = 1'b0;
  endtask

  task automatic pulse_comp_fin();
    comp_finished = 1'b1; tick(); comp_finished = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_inputs(); tick(); tick(); reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    reset = 1'b1;
    idle_inputs();
    rand_addrs();
    tick(); tick();
    check("rst_load_res", {30'd0, load_lock_res}, 32'd0);
    check("rst_comp_res", {30'd0, comp_lock_res}, 32'd0);
    reset = 1'b0;
    tick(); tick();

    // Single compute request from thread 0 with A_addr0 = 0x10.
    A_addr0 = 32'h10;
    comp_lock_req = 2'b01;
    tick();
    check("t1_grant", {30'd0, comp_lock_res}, 32'd1);
    check("t1_start", {31'd0, ctl_comp_start}, 32'd1);
    check("t1_addrA", ctl_A_addr, 32'h10);
    A_addr0 = 32'h99;                       // latched value must not follow
    tick();
    check("t1_start_once", {31'd0, ctl_comp_start}, 32'd0);
    check("t1_addr_hold", ctl_A_addr, 32'h10);
    repeat (3) tick();
    pulse_comp_fin();
    check("t1_release", {30'd0, comp_lock_res}, 32'd0);
    comp_lock_req = 2'b00;
    repeat (3) tick();

    // Both threads hold load request: grants alternate 0,1,0.
    do_reset();
    load_lock_req = 2'b11;
    tick();
    check("rr_first", {30'd0, load_lock_res}, 32'd1);
    for (int n = 0; n < 3; n++) begin
      repeat (2) tick();
      pulse_load_fin();
      tick(); tick();
      check("rr_next", {30'd0, load_lock_res}, (n % 2 == 0) ? 32'd2 : 32'd1);
    end
    load_lock_req = 2'b00;
    pulse_load_fin();
    repeat (3) tick();

    // Thread 1 owns compute; thread 0 gets load immediately.
    comp_lock_req = 2'b10;
    tick();
    load_lock_req = 2'b01;
    tick();
    check("indep_load", {30'd0, load_lock_res}, 32'd1);
    check("indep_comp", {30'd0, comp_lock_res}, 32'd2);
    // Owners drop req mid-operation: grants stay.
    load_lock_req = 2'b00; comp_lock_req = 2'b00;
    repeat (3) tick();
    check("drop_hold", {30'd0, load_lock_res}, 32'd1);
    pulse_load_fin(); pulse_comp_fin();
    repeat (2) tick();
    // Spurious finished in IDLE.
    pulse_load_fin();
    tick();
    check("spurious_fin", {30'd0, load_lock_res}, 32'd0);

    // Reset mid-BUSY, then a tie goes to thread 0.
    load_lock_req = 2'b10;
    tick(); tick();
    reset = 1'b1; load_finished = 1'b1;     // finished coincides with reset
    tick();
    reset = 1'b0; load_finished = 1'b0; load_lock_req = 2'b00;
    check("midrst_res", {30'd0, load_lock_res}, 32'd0);
    check("midrst_addr", ctl_B_addr, 32'd0);
    load_lock_req = 2'b11;
    tick();
    check("midrst_tie", {30'd0, load_lock_res}, 32'd1);
    load_lock_req = 2'b00;
    pulse_load_fin();
    repeat (2) tick();

    // Long hold without finished (times out only with LOCK_TIMEOUT_EN).
    comp_lock_req = 2'b10;
    tick();
    comp_lock_req = 2'b00;
    repeat (TMO + 4) tick();
    pulse_comp_fin();
    repeat (3) tick();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_addrs();
      if ($urandom_range(0, 3) == 0) load_lock_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) comp_lock_req = 2'($urandom_range(0, 3));
      load_finished = ($urandom_range(0, 4) == 0);
      comp_finished = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound in case the run ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
